// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit. The ID-stage
// decoder imports this package so opcode values stay in one place.
package muldiv_pkg;

   localparam int OP_W = 3;

   typedef enum logic [OP_W-1:0] {
      OP_MULT  = 3'd0,
      OP_MULTU = 3'd1,
      OP_DIV   = 3'd2,
      OP_DIVU  = 3'd3,
      OP_MTHI  = 3'd4,
      OP_MTLO  = 3'd5
   } muldiv_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } state_e;

   // True for the ops that run through the iterative datapath
   function automatic logic is_muldiv(input logic [OP_W-1:0] op);
      return (op == OP_MULT) || (op == OP_MULTU) ||
             (op == OP_DIV)  || (op == OP_DIVU);
   endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Accumulator and per-bit step for shift-add multiply / restoring divide,
// plus the sign fix-up that produces the final HI/LO values.
module muldiv_datapath
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             step,
   input  logic [OP_W-1:0]  op,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic [WIDTH-1:0] res_hi,
   output logic [WIDTH-1:0] res_lo,
   output logic             div0
);

   // Multiply: acc = {partial product, remaining multiplier bits}, opnd = multiplicand.
   // Divide:   acc = {remainder, dividend/quotient bits},          opnd = divisor.
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   opnd;
   logic               is_div;
   logic               sgn_q;
   logic               sgn_r;

   logic               signed_op;
   logic [WIDTH-1:0]   mag_a;
   logic [WIDTH-1:0]   mag_b;

   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;
   logic               div_ok;
   logic [WIDTH-1:0]   div_rem;
   logic [2*WIDTH-1:0] div_next;

   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   q_mag;
   logic [WIDTH-1:0]   r_mag;
   logic [WIDTH-1:0]   quot;
   logic [WIDTH-1:0]   rem;

   // Operand magnitudes at issue; unsigned ops pass straight through
   always_comb begin
      signed_op = (op == OP_MULT) || (op == OP_DIV);
      mag_a     = (signed_op && op_a[WIDTH-1]) ? -op_a : op_a;
      mag_b     = (signed_op && op_b[WIDTH-1]) ? -op_b : op_b;
   end

   // One iteration of each algorithm; the FSM picks which one is latched
   always_comb begin
      mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
      mul_next = {mul_sum, acc[WIDTH-1:1]};
      // Shifted remainder is WIDTH+1 bits; when it is >= divisor the
      // difference is below the divisor, so its low WIDTH bits are exact.
      div_ok   = acc[2*WIDTH-1:WIDTH-1] >= {1'b0, opnd};
      div_rem  = acc[2*WIDTH-2:WIDTH-1] - opnd;
      div_next = {(div_ok ? div_rem : acc[2*WIDTH-2:WIDTH-1]), acc[WIDTH-2:0], div_ok};
   end

   // Sign fix-up. With a zero divisor the quotient is forced to all ones;
   // the remainder already equals |a| and re-signing it restores op_a.
   always_comb begin
      prod   = sgn_q ? -acc : acc;
      q_mag  = acc[WIDTH-1:0];
      r_mag  = acc[2*WIDTH-1:WIDTH];
      quot   = sgn_q ? -q_mag : q_mag;
      rem    = sgn_r ? -r_mag : r_mag;
      res_hi = is_div ? rem : prod[2*WIDTH-1:WIDTH];
      res_lo = is_div ? (div0 ? '1 : quot) : prod[WIDTH-1:0];
   end

   // Operand capture on issue, then one step per CALC cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc    <= '0;
         opnd   <= '0;
         is_div <= 1'b0;
         sgn_q  <= 1'b0;
         sgn_r  <= 1'b0;
         div0   <= 1'b0;
      end else if (load) begin
         is_div <= (op == OP_DIV) || (op == OP_DIVU);
         sgn_q  <= signed_op & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
         sgn_r  <= signed_op & op_a[WIDTH-1];
         div0   <= (op == OP_DIV || op == OP_DIVU) && (op_b == '0);
         if (op == OP_DIV || op == OP_DIVU) begin
            acc  <= {{WIDTH{1'b0}}, mag_a};
            opnd <= mag_b;
         end else begin
            acc  <= {{WIDTH{1'b0}}, mag_b};
            opnd <= mag_a;
         end
      end else if (step) begin
         acc <= is_div ? div_next : mul_next;
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Control FSM and iteration counter live here; arithmetic is in the datapath.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic             div0,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   state_e           state;
   logic [CNT_W-1:0] cnt;
   logic             load;
   logic             step;
   logic [WIDTH-1:0] res_hi;
   logic [WIDTH-1:0] res_lo;
   logic             dp_div0;

   // Datapath strobes; a flush in the same cycle wins over a new issue
   always_comb begin
      load = (state == IDLE) && start && !flush && is_muldiv(op);
      step = (state == CALC) && !flush;
   end

   assign busy = (state != IDLE);

   muldiv_datapath #(.WIDTH(WIDTH)) u_dp (
      .clk    (clk),
      .rst    (rst),
      .load   (load),
      .step   (step),
      .op     (op),
      .op_a   (op_a),
      .op_b   (op_b),
      .res_hi (res_hi),
      .res_lo (res_lo),
      .div0   (dp_div0)
   );

   // Control FSM: issue, WIDTH iterations, fix-up and HI/LO write-back
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         hi    <= '0;
         lo    <= '0;
         done  <= 1'b0;
         div0  <= 1'b0;
      end else begin
         done <= 1'b0;
         div0 <= 1'b0;
         if (flush) begin
            state <= IDLE;
         end else begin
            case (state)
               IDLE: if (start) begin
                  case (muldiv_op_e'(op))
                     OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                        cnt   <= '0;
                        state <= CALC;
                     end
                     OP_MTHI: hi <= op_a;
                     OP_MTLO: lo <= op_a;
                     default: ;
                  endcase
               end
               CALC: begin
                  cnt <= cnt + 1'b1;
                  if (cnt == CNT_W'(WIDTH-1)) state <= FIX;
               end
               FIX: begin
                  hi    <= res_hi;
                  lo    <= res_lo;
                  done  <= 1'b1;
                  div0  <= dp_div0;
                  state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: 32-bit instance plus an 8-bit instance.
module tb_muldiv_unit;
   import muldiv_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        start, flush;
   logic [2:0]  op;
   logic [31:0] op_a, op_b;
   logic        busy, done, div0;
   logic [31:0] hi, lo;

   logic        start8, flush8;
   logic [2:0]  op8;
   logic [7:0]  a8, b8;
   logic        busy8, done8, div08;
   logic [7:0]  hi8, lo8;

   int nchk = 0;
   int nfail = 0;

   // Running totals sampled on each rising edge (pre-edge values)
   int cyc = 0, busy_tot = 0, done_tot = 0, div0_tot = 0;
   int s_cyc, s_busy, s_done, s_div0;

   always #5 clk = ~clk;

   muldiv_unit #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .op_a(op_a), .op_b(op_b),
      .flush(flush), .busy(busy), .done(done), .div0(div0), .hi(hi), .lo(lo)
   );

   muldiv_unit #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .op(op8), .op_a(a8), .op_b(b8),
      .flush(flush8), .busy(busy8), .done(done8), .div0(div08), .hi(hi8), .lo(lo8)
   );

   always @(posedge clk) begin
      cyc      <= cyc + 1;
      busy_tot <= busy_tot + int'(busy);
      done_tot <= done_tot + int'(done);
      div0_tot <= div0_tot + int'(div0 & done);
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive a one-cycle start from a negedge; returns at the next negedge
   task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      op = o; op_a = a; op_b = b; start = 1'b1;
      s_busy = busy_tot; s_done = done_tot; s_div0 = div0_tot;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      s_cyc = cyc;
   endtask

   // Edge count from the start edge (as 1) to the HI/LO write; 0 on timeout
   task automatic wait_done(output int edges);
      edges = 0;
      for (int k = 0; k < 200 && !done; k++) @(negedge clk);
      if (done) edges = cyc - s_cyc + 1;
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic run(input string tag, input logic [2:0] o, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                      input int ediv0);
      int edges;
      issue(o, a, b);
      wait_done(edges);
      chk({tag, " edges"}, 64'(edges), 64'd34);
      chk({tag, " hi"}, 64'(hi), 64'(ehi));
      chk({tag, " lo"}, 64'(lo), 64'(elo));
      chk({tag, " done pulses"}, 64'(done_tot - s_done), 64'd1);
      chk({tag, " busy cycles"}, 64'(busy_tot - s_busy), 64'd33);
      chk({tag, " div0 pulses"}, 64'(div0_tot - s_div0), 64'(ediv0));
   endtask

   initial begin
      int edges;
      rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; op_a = '0; op_b = '0;
      start8 = 1'b0; flush8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
      @(negedge clk); @(negedge clk);
      chk("reset hi", 64'(hi), 64'd0);
      chk("reset lo", 64'(lo), 64'd0);
      chk("reset busy/done/div0", 64'({busy, done, div0}), 64'd0);
      rst = 1'b0;
      @(negedge clk);

      run("multu", OP_MULTU, 32'hFFFF_FFFF, 32'd5, 32'h0000_0004, 32'hFFFF_FFFB, 0);
      run("mult",  OP_MULT,  32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 0);
      run("div neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
      run("divu", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 0);
      run("div ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 0);
      run("divu0", OP_DIVU, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF, 1);
      run("div0 signed", OP_DIV, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 1);

      // Second start while busy must be ignored
      issue(OP_MULT, 32'd6, 32'd7);
      repeat (3) @(negedge clk);
      op = OP_DIVU; op_a = 32'd9; op_b = 32'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(edges);
      chk("busy start edges", 64'(edges), 64'd34);
      chk("busy start hi", 64'(hi), 64'd0);
      chk("busy start lo", 64'(lo), 64'd42);
      chk("busy start done pulses", 64'(done_tot - s_done), 64'd1);

      // Flush at cycle 10 of a new MULT
      issue(OP_MULT, 32'd3, 32'd3);
      repeat (8) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("flush busy", 64'(busy), 64'd0);
      repeat (40) @(negedge clk);
      chk("flush hi", 64'(hi), 64'd0);
      chk("flush lo", 64'(lo), 64'd42);
      chk("flush no done", 64'(done_tot - s_done), 64'd0);

      // Flush together with a start in IDLE drops the start
      op = OP_MTHI; op_a = 32'h1111_1111; start = 1'b1; flush = 1'b1;
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      chk("flush+start hi", 64'(hi), 64'd0);

      // MTHI then MTLO on consecutive edges
      s_done = done_tot; s_busy = busy_tot;
      op = OP_MTHI; op_a = 32'hCAFE_BABE; start = 1'b1;
      @(negedge clk);
      chk("mthi hi", 64'(hi), 64'hCAFE_BABE);
      chk("mthi busy", 64'(busy), 64'd0);
      op = OP_MTLO; op_a = 32'h0BAD_F00D;
      @(negedge clk);
      start = 1'b0;
      chk("mtlo lo", 64'(lo), 64'h0BAD_F00D);
      chk("mtlo hi kept", 64'(hi), 64'hCAFE_BABE);
      @(negedge clk);
      chk("mthi/mtlo no busy/done", 64'((busy_tot - s_busy) + (done_tot - s_done)), 64'd0);

      // Ops 6/7 are no-ops
      op = 3'd6; op_a = 32'h5555_5555; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("noop busy", 64'(busy), 64'd0);
      chk("noop hi/lo", 64'({hi, lo}), {32'hCAFE_BABE, 32'h0BAD_F00D});

      // Asynchronous reset in the middle of a DIV
      issue(OP_DIV, 32'd100, 32'd7);
      repeat (5) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("async rst hi/lo", 64'({hi, lo}), 64'd0);
      chk("async rst busy/done/div0", 64'({busy, done, div0}), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // 8-bit instance: signed 0x80 * 0x80
      op8 = OP_MULT; a8 = 8'h80; b8 = 8'h80; start8 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start8 = 1'b0;
      s_cyc = cyc;
      edges = 0;
      for (int k = 0; k < 100 && !done8; k++) @(negedge clk);
      if (done8) edges = cyc - s_cyc + 1;
      chk("w8 edges", 64'(edges), 64'd10);
      chk("w8 product", 64'({hi8, lo8}), 64'h4000);

      $display("%0d/%0d checks passed", nchk - nfail, nchk);
      $finish;
   end

endmodule
